control_trace_recorder: RTL and testbench

Captures the control-unit output bundle cycle by cycle into an on-chip trace buffer, then streams the buffer out over a valid/ready read port. It sits beside the control unit that drives the ALU system and records the control words that test vectors would otherwise supply. Each stored entry is 42 bits and uses the same bit layout as the ALU-system test-vector format, so a drained trace can be written to a `.mem` file and replayed by the vector bench.

---
 rtl/control_trace_recorder.sv | 127 ++++++++++++
 tb/tb_control_trace_recorder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/control_trace_recorder.sv
// control_trace_recorder: records the control-unit output word into a small
// trace buffer (fill-and-stop or circular, optional change-only capture),
// then streams the held entries out over a valid/ready read port.
// Stored entries use the ALU-system test-vector layout {1'b0, CtrlWord}.
module control_trace_recorder #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Arm,
  input  logic          Stop,
  input  logic          Mode,
  input  logic          Dedup,
  input  logic [40:0]   CtrlWord,
  input  logic          Rd_Ready,
  output logic          Rd_Valid,
  output logic [41:0]   Rd_Data,
  output logic          Rd_Last,
  output logic [AW:0]   Count,
  output logic [1:0]    State,
  output logic          Overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    DRAIN   = 2'b10
  } state_t;

  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE    = (AW+1)'(1);

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            overflow;
  logic            have_last;
  logic [40:0]     last_word;
  logic [40:0]     mem [DEPTH];

  logic            sample;
  logic            full_stop;
  logic            wr_en;
  logic            rd_xfer;

  // Sample condition and write/transfer strobes for the current edge.
  // A Mode-0 sample while already full (possible after switching from
  // circular mode) ends the capture instead of clobbering the oldest entry.
  always_comb begin
    sample    = !Dedup || !have_last || (CtrlWord != last_word);
    full_stop = !Mode && (count == FULL);
    wr_en     = (state == CAPTURE) && !Stop && sample && !full_stop;
    rd_xfer   = Rd_Valid && Rd_Ready;
  end

  // Trace storage; deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_ptr] <= CtrlWord;
  end

  // Control FSM: pointers, occupancy, overflow flag and dedup history.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      have_last <= 1'b0;
      last_word <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Arm) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            have_last <= 1'b0;
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (Stop) begin
            state <= (count != '0) ? DRAIN : IDLE;
          end else if (sample && full_stop) begin
            state <= DRAIN;
          end else if (sample) begin
            wr_ptr    <= wr_ptr + 1'b1;
            last_word <= CtrlWord;
            have_last <= 1'b1;
            if (!Mode) begin
              count <= count + 1'b1;
              if (count == FULL - ONE) state <= DRAIN;
            end else if (count != FULL) begin
              count <= count + 1'b1;
            end else begin
              rd_ptr   <= rd_ptr + 1'b1;
              overflow <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (rd_xfer) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
            if (count == ONE) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read port is combinational from the registered pointer and memory.
  always_comb begin
    Rd_Valid = (state == DRAIN) && (count != '0);
    Rd_Data  = Rd_Valid ? {1'b0, mem[rd_ptr]} : '0;
    Rd_Last  = Rd_Valid && (count == ONE);
    Count    = count;
    State    = state;
    Overflow = overflow;
  end

endmodule

// File: tb/tb_control_trace_recorder.sv
// Bench for control_trace_recorder (DEPTH=4): directed test-plan steps
// followed by a random phase, all checked against a queue-based model.
module tb_control_trace_recorder;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          Arm = 1'b0, Stop = 1'b0, Mode = 1'b0, Dedup = 1'b0;
  logic [40:0]   CtrlWord = '0;
  logic          Rd_Ready = 1'b0;
  logic          Rd_Valid;
  logic [41:0]   Rd_Data;
  logic          Rd_Last;
  logic [AW:0]   Count;
  logic [1:0]    State;
  logic          Overflow;

  control_trace_recorder #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .Arm(Arm), .Stop(Stop), .Mode(Mode),
    .Dedup(Dedup), .CtrlWord(CtrlWord), .Rd_Ready(Rd_Ready),
    .Rd_Valid(Rd_Valid), .Rd_Data(Rd_Data), .Rd_Last(Rd_Last),
    .Count(Count), .State(State), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model: phase 0 idle, 1 capturing, 2 draining; q holds entries oldest first.
  logic [40:0] q [$];
  int          ph = 0;
  bit          m_ovf = 0;
  bit          m_have = 0;
  logic [40:0] m_last = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rn, input bit arm, input bit stop, input bit mode,
                            input bit dedup, input bit rdy, input logic [40:0] w);
    if (!rn) begin
      ph = 0; q.delete(); m_ovf = 0; m_have = 0;
    end else if (ph == 0) begin
      if (arm) begin q.delete(); m_ovf = 0; m_have = 0; ph = 1; end
    end else if (ph == 1) begin
      if (stop) ph = (q.size() > 0) ? 2 : 0;
      else if (!dedup || !m_have || w != m_last) begin
        if (!mode && q.size() == DEPTH) ph = 2;
        else begin
          q.push_back(w); m_last = w; m_have = 1;
          if (q.size() > DEPTH) begin void'(q.pop_front()); m_ovf = 1; end
          if (!mode && q.size() == DEPTH) ph = 2;
        end
      end
    end else begin
      if (rdy && q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() == 0) ph = 0;
      end
    end
  endtask

  task automatic step(input bit rn, input bit arm, input bit stop, input bit mode,
                      input bit dedup, input bit rdy, input logic [40:0] w);
    bit          v;
    logic [41:0] d;
    Reset = rn; Arm = arm; Stop = stop; Mode = mode; Dedup = dedup;
    Rd_Ready = rdy; CtrlWord = w;
    @(posedge Clock);
    model_edge(rn, arm, stop, mode, dedup, rdy, w);
    #1;
    v = (ph == 2) && (q.size() > 0);
    d = v ? {1'b0, q[0]} : 42'h0;
    chk("state",    64'(State),    64'(ph));
    chk("count",    64'(Count),    64'(q.size()));
    chk("rd_valid", 64'(Rd_Valid), 64'(v));
    chk("rd_data",  64'(Rd_Data),  64'(d));
    chk("rd_last",  64'(Rd_Last),  64'(v && q.size() == 1));
    chk("overflow", 64'(Overflow), 64'(m_ovf));
  endtask

  // shorthand: normal operation with word/ready
  task automatic run(input bit mode, input bit dedup, input bit rdy, input logic [40:0] w);
    step(1, 0, 0, mode, dedup, rdy, w);
  endtask

  task automatic arm(input bit mode, input bit dedup);
    step(1, 1, 0, mode, dedup, 0, '0);
  endtask

  task automatic drain_all();
    for (int i = 0; i < DEPTH + 2; i++) run(0, 0, 1, '0);
  endtask

  initial begin
    // Reset with Arm high
    step(0, 1, 0, 0, 0, 0, 41'h5);
    step(0, 1, 0, 0, 0, 0, 41'h5);
    chk("rst_state", 64'(State), 64'd0);
    chk("rst_count", 64'(Count), 64'd0);
    chk("rst_valid", 64'(Rd_Valid), 64'd0);
    chk("rst_data",  64'(Rd_Data), 64'd0);
    chk("rst_ovf",   64'(Overflow), 64'd0);

    // Fill-and-stop
    arm(0, 0);
    for (int i = 1; i <= 4; i++) run(0, 0, 1, 41'(i));
    chk("fill_state", 64'(State), 64'd2);
    chk("fill_count", 64'(Count), 64'd4);
    chk("fill_first", 64'(Rd_Data), 64'd1);
    run(0, 0, 1, 41'd5);
    chk("fill_second", 64'(Rd_Data), 64'd2);
    run(0, 0, 1, '0);
    run(0, 0, 1, '0);
    chk("fill_last_data", 64'(Rd_Data), 64'd4);
    chk("fill_last_flag", 64'(Rd_Last), 64'd1);
    run(0, 0, 1, '0);
    chk("fill_idle", 64'(State), 64'd0);

    // Circular
    arm(1, 0);
    for (int i = 1; i <= 6; i++) run(1, 0, 0, 41'(i));
    step(1, 0, 1, 1, 0, 0, '0);
    chk("circ_ovf",   64'(Overflow), 64'd1);
    chk("circ_count", 64'(Count), 64'd4);
    chk("circ_head",  64'(Rd_Data), 64'd3);
    drain_all();
    chk("circ_ovf_idle", 64'(Overflow), 64'd1);
    arm(0, 0);
    chk("circ_ovf_clr", 64'(Overflow), 64'd0);
    step(1, 0, 1, 0, 0, 0, '0);

    // Dedup: 7,7,7,9,9,7 -> 7,9,7
    arm(1, 1);
    run(1, 1, 0, 41'd7); run(1, 1, 0, 41'd7); run(1, 1, 0, 41'd7);
    run(1, 1, 0, 41'd9); run(1, 1, 0, 41'd9); run(1, 1, 0, 41'd7);
    step(1, 0, 1, 1, 1, 0, '0);
    chk("dedup_count", 64'(Count), 64'd3);
    drain_all();

    // Backpressure on a full buffer
    arm(0, 0);
    for (int i = 0; i < 4; i++) run(0, 0, 0, 41'h1_0000_0000 + 41'(i * 17));
    run(0, 0, 1, '0); run(0, 0, 0, '0); run(0, 0, 0, '0);
    run(0, 0, 1, '0); run(0, 0, 0, '0); run(0, 0, 1, '0); run(0, 0, 1, '0);
    chk("bp_idle", 64'(State), 64'd0);

    // Arm then Stop immediately
    arm(0, 0);
    step(1, 0, 1, 0, 0, 1, '0);
    chk("armstop_state", 64'(State), 64'd0);

    // Stop with the 4th sample
    arm(0, 0);
    run(0, 0, 0, 41'd11); run(0, 0, 0, 41'd12); run(0, 0, 0, 41'd13);
    step(1, 0, 1, 0, 0, 0, 41'd14);
    chk("stop4_count", 64'(Count), 64'd3);
    chk("stop4_state", 64'(State), 64'd2);

    // Arm during drain is ignored, then reset mid-drain
    step(1, 1, 0, 0, 0, 0, '0);
    chk("arm_drain", 64'(State), 64'd2);
    run(0, 0, 1, '0);
    step(0, 0, 0, 0, 0, 1, '0);
    chk("rst_drain_state", 64'(State), 64'd0);
    chk("rst_drain_count", 64'(Count), 64'd0);

    // Random phase
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 1) != 0) ? 41'($urandom_range(0, 3))
                                       : {9'($urandom), 32'($urandom)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
